// File: rtl/ifetch32.sv
// Instruction fetch: PC sequencing, branch/jump select and a synchronous
// instruction RAM that can be reloaded over a UART program-load session.
module ifetch32 #(
   parameter int          ROM_AW   = 14,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [31:0]       Addr_Result,
   input  logic              Zero,
   input  logic [31:0]       Read_data_1,
   input  logic              Branch,
   input  logic              nBranch,
   input  logic              Jmp,
   input  logic              Jal,
   input  logic              Jr,
   input  logic              stall,
   input  logic              upg_active,
   input  logic              upg_wen,
   input  logic [ROM_AW-1:0] upg_adr,
   input  logic [31:0]       upg_dat,
   output logic [31:0]       Instruction,
   output logic [31:0]       PC,
   output logic [31:0]       PC_plus_4,
   output logic [31:0]       link_addr,
   output logic              align_err,
   output logic [31:0]       retired
);

   typedef enum logic [1:0] {
      S_RESTART,
      S_RUN,
      S_LOAD
   } state_t;

   localparam int WORDS = 1 << ROM_AW;

   logic [31:0]       r_mem [WORDS];
   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_pc;
   logic [31:0]       r_instr;
   logic [31:0]       r_retired;
   logic              r_align_err;

   logic [31:0]       w_pc4;
   logic [31:0]       w_target;
   logic [31:0]       w_next_pc;
   logic              w_mis;
   logic [ROM_AW-1:0] w_rst_idx;
   logic [31:0]       w_pc_nxt;
   logic [31:0]       w_ret_nxt;
   logic              w_aerr_nxt;
   logic              w_rd_en;
   logic [ROM_AW-1:0] w_rd_idx;
   logic              w_instr_clr;
   logic              w_wr_en;

   assign w_pc4     = r_pc + 32'd4;
   assign w_rst_idx = RESET_PC[ROM_AW+1:2];

   always_comb begin
      w_target = w_pc4;
      if (Jr)
         w_target = Read_data_1;
      else if (Jmp | Jal)
         w_target = {w_pc4[31:28], r_instr[25:0], 2'b00};
      else if ((Branch & Zero) | (nBranch & ~Zero))
         w_target = Addr_Result;
   end

   assign w_next_pc = {w_target[31:2], 2'b00};
   assign w_mis     = |w_target[1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ret_nxt   = r_retired;
      w_aerr_nxt  = r_align_err;
      w_rd_en     = 1'b0;
      w_rd_idx    = w_next_pc[ROM_AW+1:2];
      w_instr_clr = 1'b0;
      w_wr_en     = 1'b0;
      unique case (r_state)
         S_RUN: begin
            if (upg_active) begin
               w_state_nxt = S_LOAD;
               w_pc_nxt    = RESET_PC;
               w_instr_clr = 1'b1;
            end else if (!stall) begin
               w_pc_nxt   = w_next_pc;
               w_rd_en    = 1'b1;
               w_ret_nxt  = r_retired + 32'd1;
               w_aerr_nxt = r_align_err | w_mis;
            end
         end
         S_RESTART: begin
            w_pc_nxt = RESET_PC;
            if (upg_active) begin
               w_state_nxt = S_LOAD;
               w_instr_clr = 1'b1;
            end else begin
               w_state_nxt = S_RUN;
               w_rd_en     = 1'b1;
               w_rd_idx    = w_rst_idx;
            end
         end
         S_LOAD: begin
            w_pc_nxt    = RESET_PC;
            w_instr_clr = 1'b1;
            w_wr_en     = upg_wen;
            if (!upg_active) begin
               w_state_nxt = S_RESTART;
               w_ret_nxt   = 32'd0;
            end
         end
         default: w_state_nxt = S_RESTART;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_state     <= S_RESTART;
         r_pc        <= RESET_PC;
         r_instr     <= 32'h0;
         r_retired   <= 32'h0;
         r_align_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_retired   <= w_ret_nxt;
         r_align_err <= w_aerr_nxt;
         if (w_instr_clr)
            r_instr <= 32'h0;
         else if (w_rd_en)
            r_instr <= r_mem[w_rd_idx];
      end
   end

   // No reset on the array: contents survive rst_n, but a write under reset is dropped
   always_ff @(posedge clock) begin
      if (rst_n && w_wr_en)
         r_mem[upg_adr] <= upg_dat;
   end

   assign Instruction = r_instr;
   assign PC          = r_pc;
   assign PC_plus_4   = w_pc4;
   assign link_addr   = w_pc4;
   assign align_err   = r_align_err;
   assign retired     = r_retired;

endmodule

// File: tb/tb_ifetch32.sv
// Bench for ifetch32: directed fetch/branch/stall/load/reset steps
// followed by randomized control against a behavioural fetch model.
module tb_ifetch32;

   localparam int AW = 14;

   logic          clock = 1'b0;
   logic          rst_n;
   logic [31:0]   Addr_Result;
   logic          Zero;
   logic [31:0]   Read_data_1;
   logic          Branch, nBranch, Jmp, Jal, Jr;
   logic          stall;
   logic          upg_active, upg_wen;
   logic [AW-1:0] upg_adr;
   logic [31:0]   upg_dat;
   logic [31:0]   Instruction, PC, PC_plus_4, link_addr, retired;
   logic          align_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_ins, m_ret;
   logic        m_aerr;
   logic [31:0] m_mem [0:(1<<AW)-1];
   logic [31:0] img [0:511];
   logic [31:0] hold_pc, hold_ins, hold_ret;

   always #5 clock = ~clock;

   ifetch32 #(.ROM_AW(AW), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .Addr_Result (Addr_Result),
      .Zero        (Zero),
      .Read_data_1 (Read_data_1),
      .Branch      (Branch),
      .nBranch     (nBranch),
      .Jmp         (Jmp),
      .Jal         (Jal),
      .Jr          (Jr),
      .stall       (stall),
      .upg_active  (upg_active),
      .upg_wen     (upg_wen),
      .upg_adr     (upg_adr),
      .upg_dat     (upg_dat),
      .Instruction (Instruction),
      .PC          (PC),
      .PC_plus_4   (PC_plus_4),
      .link_addr   (link_addr),
      .align_err   (align_err),
      .retired     (retired)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"}, PC, m_pc);
      chk({tag, ".ins"}, Instruction, m_ins);
      chk({tag, ".ret"}, retired, m_ret);
      chk({tag, ".aerr"}, {31'b0, align_err}, {31'b0, m_aerr});
      chk({tag, ".pc4"}, PC_plus_4, m_pc + 32'd4);
      chk({tag, ".link"}, link_addr, m_pc + 32'd4);
   endtask

   task automatic clear_ctrl();
      Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0;
      Zero = 0; stall = 0; Addr_Result = 0; Read_data_1 = 0;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom();
      w[13:8] = 6'b0;
      return w;
   endfunction

   // One RUN-state edge; expected state derived from the fetch rules.
   task automatic adv(input string tag);
      logic [31:0] pc4, tgt;
      pc4 = m_pc + 32'd4;
      if (!stall) begin
         if (Jr)
            tgt = Read_data_1;
         else if (Jmp || Jal)
            tgt = {pc4[31:28], m_ins[25:0], 2'b00};
         else if ((Branch && Zero) || (nBranch && !Zero))
            tgt = Addr_Result;
         else
            tgt = pc4;
         if (tgt[1:0] != 2'b00) m_aerr = 1'b1;
         m_pc  = tgt & 32'hFFFF_FFFC;
         m_ins = m_mem[m_pc[AW+1:2]];
         m_ret = m_ret + 32'd1;
      end
      step();
      chk_all(tag);
   endtask

   task automatic jr_to(input logic [31:0] a, input string tag);
      clear_ctrl();
      Jr = 1; Read_data_1 = a;
      adv(tag);
      clear_ctrl();
   endtask

   task automatic load(input int base, input int n);
      upg_active = 1;
      upg_wen    = 1;
      upg_adr    = AW'($urandom_range(2, 511));
      upg_dat    = $urandom();
      step();
      m_pc = 0; m_ins = 0;
      chk_all("load_enter");
      for (int i = 0; i < n; i++) begin
         upg_wen    = 1;
         upg_adr    = AW'(base + i);
         upg_dat    = img[base + i];
         upg_active = (i != n - 1);
         step();
         m_mem[base + i] = img[base + i];
         if (i == n - 1) m_ret = 0;
         chk({"load_ins"}, Instruction, 32'h0);
         chk({"load_pc"}, PC, 32'h0);
      end
      upg_wen = 0; upg_active = 0;
      chk_all("load_restart");
      step();
      m_ins = m_mem[0];
      chk_all("load_first");
   endtask

   initial begin
      clear_ctrl();
      rst_n = 0; upg_active = 0; upg_wen = 0; upg_adr = 0; upg_dat = 0;
      step(); step();
      m_pc = 0; m_ins = 0; m_ret = 0; m_aerr = 0;
      chk_all("reset");

      for (int i = 0; i < 512; i++) img[i] = rand_word();
      rst_n = 1;
      load(0, 512);

      rst_n = 0;
      step();
      m_pc = 0; m_ins = 0; m_ret = 0; m_aerr = 0;
      chk_all("seq_c1");
      rst_n = 1;
      step();
      m_ins = m_mem[0];
      chk_all("seq_c2");
      chk("seq_w0", Instruction, img[0]);
      for (int k = 1; k <= 3; k++) adv("seq");
      chk("seq_pc12", PC, 32'hC);
      chk("seq_w3", Instruction, img[3]);
      chk("seq_ret3", retired, 32'd3);

      jr_to(32'h10, "jr10");
      Branch = 1; Zero = 1; Addr_Result = 32'h40;
      adv("beq_t");
      chk("beq_taken_pc", PC, 32'h40);
      jr_to(32'h10, "jr10b");
      Branch = 1; Zero = 0; Addr_Result = 32'h40;
      adv("beq_nt");
      chk("beq_fall_pc", PC, 32'h14);
      clear_ctrl();
      nBranch = 1; Zero = 0; Addr_Result = 32'h40;
      adv("bne_t");
      chk("bne_taken_pc", PC, 32'h40);
      clear_ctrl();
      Jr = 1; Jmp = 1; Read_data_1 = 32'h80;
      adv("jr_wins");
      chk("jr_wins_pc", PC, 32'h80);
      clear_ctrl();
      Jal = 1;
      adv("jal");
      clear_ctrl();
      jr_to(32'h0001_0010, "wrap");
      chk("wrap_ins", Instruction, img[4]);
      chk("no_aerr", {31'b0, align_err}, 32'd0);

      jr_to(32'h20, "jr20");
      hold_pc = PC; hold_ins = Instruction; hold_ret = retired;
      for (int k = 0; k < 3; k++) begin
         stall = 1; Jr = 1; Read_data_1 = $urandom();
         adv("stall");
         chk("stall_pc", PC, hold_pc);
         chk("stall_ins", Instruction, hold_ins);
         chk("stall_ret", retired, hold_ret);
      end
      clear_ctrl();
      adv("unstall");
      chk("unstall_pc", PC, 32'h24);

      jr_to(32'h102, "mis");
      chk("mis_pc", PC, 32'h100);
      chk("mis_aerr", {31'b0, align_err}, 32'd1);
      for (int k = 0; k < 10; k++) adv("mis_hold");
      chk("mis_sticky", {31'b0, align_err}, 32'd1);

      img[0] = 32'h2408_0005;
      img[1] = 32'h0;
      load(0, 2);
      chk("prog_pc", PC, 32'h0);
      chk("prog_ins", Instruction, 32'h2408_0005);
      chk("prog_ret", retired, 32'd0);

      upg_active = 1; upg_wen = 0;
      step();
      m_pc = 0; m_ins = 0;
      chk_all("ml_enter");
      img[2] = rand_word();
      upg_wen = 1; upg_adr = AW'(2); upg_dat = img[2];
      step();
      m_mem[2] = img[2];
      chk_all("ml_write");
      rst_n = 0; upg_adr = AW'(3); upg_dat = ~m_mem[3];
      step();
      m_pc = 0; m_ins = 0; m_ret = 0; m_aerr = 0;
      chk_all("ml_reset");
      rst_n = 1; upg_active = 0; upg_wen = 0;
      step();
      m_ins = m_mem[0];
      chk_all("ml_restart");
      jr_to(32'hC, "ml_adr3");
      chk("ml_intact3", Instruction, img[3]);
      jr_to(32'h8, "ml_adr2");
      chk("ml_kept2", Instruction, img[2]);

      for (int k = 0; k < 400; k++) begin
         logic [31:0] r;
         r = $urandom();
         Jr      = ($urandom_range(0, 5) == 0);
         Jmp     = ($urandom_range(0, 5) == 0);
         Jal     = ($urandom_range(0, 5) == 0);
         Branch  = ($urandom_range(0, 2) == 0);
         nBranch = ($urandom_range(0, 2) == 0);
         Zero    = 1'($urandom_range(0, 1));
         stall   = ($urandom_range(0, 4) == 0);
         Read_data_1 = {r[31:16], 6'b0, r[9:2], 2'b00};
         if ($urandom_range(0, 7) == 0) Read_data_1[1:0] = r[1:0];
         r = $urandom();
         Addr_Result = {r[31:16], 6'b0, r[9:2], 2'b00};
         if ($urandom_range(0, 7) == 0) Addr_Result[1:0] = r[1:0];
         upg_wen = 1'($urandom_range(0, 1));
         upg_adr = AW'($urandom_range(0, 511));
         upg_dat = $urandom();
         adv("rnd");
      end
      clear_ctrl();
      upg_wen = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
